// File: rtl/gearbox_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : gearbox_ctrl
// Brief   : N-gear automatic gearbox controller with hysteresis thresholds,
//           dwell debounce and post-shift hold-off. Define GEARBOX_KICKDOWN_EN
//           to enable single-sample kickdown below KICK_TH.
// Revision: 1.0  initial release
// ============================================================================
module gearbox_ctrl #(
    parameter int RPM_W    = 8,
    parameter int GEARS    = 5,
    parameter int UP_TH    = 200,
    parameter int DN_TH    = 80,
    parameter int DWELL    = 4,
    parameter int HOLD_CYC = 8,
    parameter int KICK_TH  = 30
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [RPM_W-1:0]           rpm,
    input  logic                       rpm_valid,
    input  logic                       A,
    output logic [$clog2(GEARS+1)-1:0] gear,
    output logic [1:0]                 M,
    output logic                       AC
);

    localparam int c_gear_w = $clog2(GEARS + 1);
    localparam int c_cnt_w  = $clog2(DWELL + 1);
    localparam int c_hold_w = $clog2(HOLD_CYC + 1);

    localparam logic [RPM_W-1:0]    c_up_th    = RPM_W'(UP_TH);
    localparam logic [RPM_W-1:0]    c_dn_th    = RPM_W'(DN_TH);
    localparam logic [RPM_W-1:0]    c_kick_th  = RPM_W'(KICK_TH);
    localparam logic [c_gear_w-1:0] c_gears    = c_gear_w'(GEARS);
    localparam logic [c_gear_w-1:0] c_gear_one = c_gear_w'(1);
    localparam logic [c_cnt_w-1:0]  c_dwell    = c_cnt_w'(DWELL);
    localparam logic [c_cnt_w-1:0]  c_dwell_m1 = c_cnt_w'(DWELL - 1);
    localparam logic [c_cnt_w-1:0]  c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_hold_w-1:0] c_hold_m1  = c_hold_w'(HOLD_CYC - 1);
    localparam logic [c_hold_w-1:0] c_hold_one = c_hold_w'(1);

`ifdef GEARBOX_KICKDOWN_EN
    localparam logic c_kick_en = 1'b1;
`else
    localparam logic c_kick_en = 1'b0;
`endif

    localparam logic [1:0] c_m_none = 2'b00;
    localparam logic [1:0] c_m_up   = 2'b01;
    localparam logic [1:0] c_m_down = 2'b10;

    typedef enum logic [1:0] {
        S_OFF     = 2'd0,
        S_NEUTRAL = 2'd1,
        S_DRIVE   = 2'd2,
        S_HOLD    = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [c_gear_w-1:0] gear_q, gear_d;
    logic [1:0]          m_q, m_d;
    logic                ac_q, ac_d;
    logic [c_cnt_w-1:0]  up_cnt_q, up_cnt_d;
    logic [c_cnt_w-1:0]  dn_cnt_q, dn_cnt_d;
    logic [c_hold_w-1:0] hold_cnt_q, hold_cnt_d;

    logic w_up_smp;
    logic w_dn_smp;
    logic w_kick;

    assign w_up_smp = rpm_valid && (rpm >= c_up_th);
    assign w_dn_smp = rpm_valid && (rpm <= c_dn_th);
    assign w_kick   = c_kick_en && rpm_valid && (rpm <= c_kick_th) && (gear_q > c_gear_one);

    always_comb begin
        state_d    = state_q;
        gear_d     = gear_q;
        m_d        = c_m_none;
        up_cnt_d   = up_cnt_q;
        dn_cnt_d   = dn_cnt_q;
        hold_cnt_d = hold_cnt_q;

        if (!A) begin
            state_d    = S_OFF;
            gear_d     = '0;
            up_cnt_d   = '0;
            dn_cnt_d   = '0;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    state_d    = S_NEUTRAL;
                    up_cnt_d   = '0;
                    dn_cnt_d   = '0;
                    hold_cnt_d = '0;
                end
                S_NEUTRAL: begin
                    dn_cnt_d = '0;
                    if (rpm_valid) begin
                        if (!w_up_smp) begin
                            up_cnt_d = '0;
                        end else if (up_cnt_q >= c_dwell_m1) begin
                            gear_d     = c_gear_one;
                            m_d        = c_m_up;
                            state_d    = S_HOLD;
                            up_cnt_d   = '0;
                            hold_cnt_d = '0;
                        end else begin
                            up_cnt_d = up_cnt_q + c_cnt_one;
                        end
                    end
                end
                S_DRIVE: begin
                    if (w_kick) begin
                        gear_d     = gear_q - c_gear_one;
                        m_d        = c_m_down;
                        state_d    = S_HOLD;
                        up_cnt_d   = '0;
                        dn_cnt_d   = '0;
                        hold_cnt_d = '0;
                    end else if (w_up_smp) begin
                        dn_cnt_d = '0;
                        if (up_cnt_q >= c_dwell_m1) begin
                            if (gear_q < c_gears) begin
                                gear_d     = gear_q + c_gear_one;
                                m_d        = c_m_up;
                                state_d    = S_HOLD;
                                up_cnt_d   = '0;
                                hold_cnt_d = '0;
                            end else begin
                                // Top gear: streak pins at DWELL, no shift.
                                up_cnt_d = c_dwell;
                            end
                        end else begin
                            up_cnt_d = up_cnt_q + c_cnt_one;
                        end
                    end else if (w_dn_smp) begin
                        up_cnt_d = '0;
                        if (dn_cnt_q >= c_dwell_m1) begin
                            gear_d     = gear_q - c_gear_one;
                            m_d        = c_m_down;
                            state_d    = S_HOLD;
                            dn_cnt_d   = '0;
                            hold_cnt_d = '0;
                        end else begin
                            dn_cnt_d = dn_cnt_q + c_cnt_one;
                        end
                    end else if (rpm_valid) begin
                        up_cnt_d = '0;
                        dn_cnt_d = '0;
                    end
                end
                S_HOLD: begin
                    up_cnt_d = '0;
                    dn_cnt_d = '0;
                    if (w_kick) begin
                        gear_d     = gear_q - c_gear_one;
                        m_d        = c_m_down;
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q >= c_hold_m1) begin
                        hold_cnt_d = '0;
                        state_d    = (gear_q != '0) ? S_DRIVE : S_NEUTRAL;
                    end else begin
                        hold_cnt_d = hold_cnt_q + c_hold_one;
                    end
                end
                default: begin
                    state_d    = S_OFF;
                    gear_d     = '0;
                    up_cnt_d   = '0;
                    dn_cnt_d   = '0;
                    hold_cnt_d = '0;
                end
            endcase
        end

        ac_d = (state_d != S_OFF);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_OFF;
            gear_q     <= '0;
            m_q        <= c_m_none;
            ac_q       <= 1'b0;
            up_cnt_q   <= '0;
            dn_cnt_q   <= '0;
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gear_q     <= gear_d;
            m_q        <= m_d;
            ac_q       <= ac_d;
            up_cnt_q   <= up_cnt_d;
            dn_cnt_q   <= dn_cnt_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign gear = gear_q;
    assign M    = m_q;
    assign AC   = ac_q;

endmodule
`default_nettype wire

// File: tb/tb_gearbox_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_gearbox_ctrl
// Brief   : Self-checking bench for gearbox_ctrl against a streak/hold model.
// Revision: 1.0  initial release
// ============================================================================
module tb_gearbox_ctrl;

    localparam int RPM_W    = 8;
    localparam int GEARS    = 5;
    localparam int UP_TH    = 200;
    localparam int DN_TH    = 80;
    localparam int DWELL    = 4;
    localparam int HOLD_CYC = 8;
    localparam int KICK_TH  = 30;
`ifdef GEARBOX_KICKDOWN_EN
    localparam bit KICK_EN = 1'b1;
`else
    localparam bit KICK_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [RPM_W-1:0] rpm;
    logic             rpm_valid;
    logic             A;
    logic [2:0]       gear;
    logic [1:0]       M;
    logic             AC;

    int checks = 0;
    int passed = 0;

    // Reference model: engine-on flag, gear number, streak lengths and
    // remaining hold-off cycles.
    bit e_on;
    int e_gear, e_m, e_up, e_dn, e_hold;

    gearbox_ctrl #(
        .RPM_W(RPM_W), .GEARS(GEARS), .UP_TH(UP_TH), .DN_TH(DN_TH),
        .DWELL(DWELL), .HOLD_CYC(HOLD_CYC), .KICK_TH(KICK_TH)
    ) dut (
        .clk(clk), .reset(reset), .rpm(rpm), .rpm_valid(rpm_valid), .A(A),
        .gear(gear), .M(M), .AC(AC)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] exp_out();
        return {e_on, 2'(e_m), 3'(e_gear)};
    endfunction

    task automatic model_step(input int r, input bit v, input bit a, input bit rs);
        bit kick;
        if (rs || !a) begin
            e_on = 0; e_gear = 0; e_m = 0; e_up = 0; e_dn = 0; e_hold = 0;
        end else if (!e_on) begin
            e_on = 1; e_m = 0; e_up = 0; e_dn = 0; e_hold = 0;
        end else begin
            e_m  = 0;
            kick = KICK_EN && v && (r <= KICK_TH) && (e_gear > 1);
            if (e_hold > 0) begin
                e_up = 0; e_dn = 0;
                if (kick) begin
                    e_gear--; e_m = 2; e_hold = HOLD_CYC;
                end else begin
                    e_hold--;
                end
            end else if (v) begin
                if (kick) begin
                    e_gear--; e_m = 2; e_hold = HOLD_CYC; e_up = 0; e_dn = 0;
                end else if (r >= UP_TH) begin
                    e_dn = 0;
                    e_up = (e_up + 1 > DWELL) ? DWELL : e_up + 1;
                    if (e_up == DWELL && e_gear < GEARS) begin
                        e_gear++; e_m = 1; e_hold = HOLD_CYC; e_up = 0;
                    end
                end else if (r <= DN_TH && e_gear > 0) begin
                    e_up = 0;
                    e_dn++;
                    if (e_dn == DWELL) begin
                        e_gear--; e_m = 2; e_hold = HOLD_CYC; e_dn = 0;
                    end
                end else begin
                    e_up = 0; e_dn = 0;
                end
            end
        end
    endtask

    task automatic cyc(input int r, input bit v, input bit a, input bit rs);
        rpm = r[RPM_W-1:0]; rpm_valid = v; A = a; reset = rs;
        @(posedge clk);
        model_step(r, v, a, rs);
        #1;
    endtask

    function automatic int hi_rpm();
        return int'($urandom_range(255, UP_TH));
    endfunction

    function automatic int band_rpm();
        return int'($urandom_range(UP_TH - 1, DN_TH + 1));
    endfunction

    function automatic int lo_rpm();
        return int'($urandom_range(DN_TH, KICK_TH + 1));
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            cyc(int'($urandom_range(255, 0)), 1'b1, 1'b1, 1'b1);
            checks++;
            if ({AC, M, gear} !== 6'b0) $display("FAIL reset_hold cyc=%0d got=%b exp=%b", i, {AC, M, gear}, 6'b0);
            else passed++;
        end
        for (int i = 0; i < 2; i++) begin
            cyc(0, 1'b0, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL reset_release cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        checks++;
        if (AC !== 1'b1 || gear !== 3'd0) $display("FAIL ac_on got AC=%b gear=%0d exp AC=1 gear=0", AC, gear);
        else passed++;
    endtask

    task automatic test_upshift();
        for (int i = 1; i <= DWELL; i++) begin
            cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL up_first cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        checks++;
        if (gear !== 3'd1 || M !== 2'b01) $display("FAIL up_to_1 got gear=%0d M=%b exp gear=1 M=01", gear, M);
        else passed++;
        for (int i = 1; i <= HOLD_CYC + DWELL; i++) begin
            cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL up_second cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
            checks++;
            if (i < HOLD_CYC + DWELL && (gear !== 3'd1 || M !== 2'b00))
                $display("FAIL up_spacing cyc=%0d got gear=%0d M=%b exp gear=1 M=00", i, gear, M);
            else if (i == HOLD_CYC + DWELL && (gear !== 3'd2 || M !== 2'b01))
                $display("FAIL up_to_2 got gear=%0d M=%b exp gear=2 M=01", gear, M);
            else passed++;
        end
    endtask

    task automatic test_hysteresis();
        int pat[7] = '{210, 210, 150, 210, 210, 210, 210};
        for (int i = 1; i <= HOLD_CYC + DWELL; i++) cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < HOLD_CYC; i++) cyc(band_rpm(), 1'b1, 1'b1, 1'b0);
        checks++;
        if ({AC, M, gear} !== exp_out() || gear !== 3'd3) $display("FAIL hyst_start got=%b exp=%b", {AC, M, gear}, exp_out());
        else passed++;
        for (int i = 0; i < 7; i++) begin
            cyc(pat[i], 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL hyst_model cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
            checks++;
            if (gear !== ((i == 6) ? 3'd4 : 3'd3)) $display("FAIL hyst_gear cyc=%0d got=%0d exp=%0d", i, gear, (i == 6) ? 4 : 3);
            else passed++;
        end
    endtask

    task automatic test_top_gear();
        for (int i = 1; i <= HOLD_CYC + DWELL; i++) cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
        checks++;
        if (gear !== 3'd5 || M !== 2'b01) $display("FAIL top_reach got gear=%0d M=%b exp gear=5 M=01", gear, M);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            cyc(250, 1'b1, 1'b1, 1'b0);
            checks++;
            if (gear !== 3'd5 || M !== 2'b00) $display("FAIL top_stay cyc=%0d got gear=%0d M=%b exp gear=5 M=00", i, gear, M);
            else passed++;
        end
        for (int i = 1; i <= DWELL; i++) begin
            cyc(50, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL top_down cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        checks++;
        if (gear !== 3'd4 || M !== 2'b10) $display("FAIL top_to_4 got gear=%0d M=%b exp gear=4 M=10", gear, M);
        else passed++;
    endtask

    task automatic test_down_to_neutral();
        for (int i = 1; i <= 4 * (HOLD_CYC + DWELL); i++) begin
            cyc(lo_rpm(), 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL down_model cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        checks++;
        if (gear !== 3'd0 || M !== 2'b10 || AC !== 1'b1) $display("FAIL down_to_0 got gear=%0d M=%b AC=%b exp gear=0 M=10 AC=1", gear, M, AC);
        else passed++;
        for (int i = 0; i < 3; i++) cyc(band_rpm(), 1'b1, 1'b1, 1'b0);
        cyc(hi_rpm(), 1'b1, 1'b0, 1'b0);
        checks++;
        if ({AC, M, gear} !== 6'b0) $display("FAIL engine_off got=%b exp=%b", {AC, M, gear}, 6'b0);
        else passed++;
        cyc(hi_rpm(), 1'b1, 1'b0, 1'b0);
        cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
        checks++;
        if ({AC, M, gear} !== 6'b100000) $display("FAIL engine_on got=%b exp=%b", {AC, M, gear}, 6'b100000);
        else passed++;
    endtask

    task automatic test_kickdown();
        for (int i = 1; i <= DWELL + 3 * (HOLD_CYC + DWELL); i++) begin
            cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL kick_climb cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        cyc(20, 1'b1, 1'b1, 1'b0);
        checks++;
        if (gear !== (KICK_EN ? 3'd3 : 3'd4) || M !== (KICK_EN ? 2'b10 : 2'b00))
            $display("FAIL kick_edge got gear=%0d M=%b exp gear=%0d M=%0d", gear, M, KICK_EN ? 3 : 4, KICK_EN ? 2 : 0);
        else passed++;
        for (int i = 0; i < 20; i++) begin
            cyc(20, 1'b1, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL kick_after cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        cyc(0, 1'b0, 1'b1, 1'b1);
        cyc(0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DWELL - 1; i++) cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
        cyc(hi_rpm(), 1'b1, 1'b1, 1'b1);
        checks++;
        if ({AC, M, gear} !== 6'b0) $display("FAIL reset_mid_dwell got=%b exp=%b", {AC, M, gear}, 6'b0);
        else passed++;
        cyc(0, 1'b0, 1'b1, 1'b0);
        cyc(hi_rpm(), 1'b1, 1'b1, 1'b0);
        checks++;
        if (gear !== 3'd0) $display("FAIL reset_cleared_streak got gear=%0d exp=0", gear);
        else passed++;
    endtask

    task automatic test_invalid_gaps();
        for (int i = 0; i < 80; i++) begin
            cyc(($urandom_range(1, 0) != 0) ? hi_rpm() : band_rpm(), ($urandom_range(2, 0) == 0), 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL gaps cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
        for (int i = 0; i < 2 * DWELL; i++) begin
            cyc(((i % 2) == 0) ? hi_rpm() : 0, (i % 2) == 0, 1'b1, 1'b0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL gaps_alt cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
        end
    endtask

    task automatic test_random();
        int r, cat;
        for (int i = 0; i < 2000; i++) begin
            cat = int'($urandom_range(4, 0));
            case (cat)
                0: r = hi_rpm();
                1: r = lo_rpm();
                2: r = band_rpm();
                3: r = int'($urandom_range(KICK_TH, 0));
                default: r = int'($urandom_range(255, 0));
            endcase
            cyc(r, $urandom_range(4, 0) != 0, $urandom_range(60, 0) != 0, $urandom_range(300, 0) == 0);
            checks++;
            if ({AC, M, gear} !== exp_out()) $display("FAIL random cyc=%0d got=%b exp=%b", i, {AC, M, gear}, exp_out());
            else passed++;
            checks++;
            if (M === 2'b11) $display("FAIL m_illegal cyc=%0d got=%b exp=not 11", i, M);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; A = 1'b0; rpm = '0; rpm_valid = 1'b0;
        e_on = 0; e_gear = 0; e_m = 0; e_up = 0; e_dn = 0; e_hold = 0;
        test_reset();
        test_upshift();
        test_hysteresis();
        test_top_gear();
        test_down_to_neutral();
        test_kickdown();
        test_reset_mid();
        test_invalid_gaps();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/gearbox_ctrl.md
Name: gearbox_ctrl

Overview:
Parametrised automatic-gearbox controller that generalises the 2-bit RPM classifier plus gear-change FSM pair.
- Accepts a multi-bit RPM sample stream and an engine on/off input.
- Drives N gears using hysteresis thresholds, a dwell (debounce) counter and a post-shift hold-off.
- Sits between the RPM sensor front-end and the dashboard/actuator logic.

Parameters:
RPM_W, 8, width of RPM sample
GEARS, 5, number of forward gears (gear 0 = neutral), must be 2..15
UP_TH, 200, rpm >= UP_TH qualifies an upshift sample
DN_TH, 80, rpm <= DN_TH qualifies a downshift sample; must be < UP_TH
DWELL, 4, consecutive qualifying valid samples required to shift, >= 1
HOLD_CYC, 8, clock cycles after a shift during which rpm is ignored, >= 1
KICK_TH, 30, immediate-downshift threshold (only with GEARBOX_KICKDOWN_EN), must be < DN_TH

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
rpm  input  RPM_W  RPM sample, unsigned
rpm_valid  input  1  rpm is a valid sample this cycle
A  input  1  1 = engine on, 0 = off
gear  output  $clog2(GEARS+1)  current gear, 0 = neutral
M  output  2  shift pulse: 00 none, 01 up, 10 down, 11 never driven
AC  output  1  engine-on indicator

Behaviour:
- Interface: one clock clk; reset is synchronous and active-high. All outputs are registered.
- Reset values: state OFF, gear=0, M=00, AC=0, up_cnt=0, dn_cnt=0, hold_cnt=0.
- States: OFF, NEUTRAL, DRIVE, HOLD.
- A=0 overrides everything. From any state, next cycle: OFF, gear=0, M=00, AC=0, all counters cleared.
- OFF: when A=1, go to NEUTRAL. AC=1 is visible the following cycle. rpm is ignored in OFF.
- NEUTRAL (gear=0):
  - Valid sample with rpm>=UP_TH increments up_cnt.
  - When up_cnt would reach DWELL: gear<=1, M<=01, go to HOLD.
- DRIVE (gear>=1), on a valid sample:
  - rpm>=UP_TH: up_cnt++ and dn_cnt cleared.
  - rpm<=DN_TH: dn_cnt++ and up_cnt cleared.
  - DN_TH<rpm<UP_TH (hysteresis band): both counters cleared.
- DRIVE shift decisions:
  - up_cnt reaches DWELL and gear<GEARS: gear+1, M=01, go to HOLD.
  - up_cnt reaches DWELL and gear==GEARS: no shift; up_cnt saturates at DWELL.
  - dn_cnt reaches DWELL and gear>1: gear-1, M=10, go to HOLD.
  - dn_cnt reaches DWELL and gear==1: gear=0, M=10, go to HOLD. HOLD then exits to NEUTRAL.
- rpm_valid=0 in NEUTRAL or DRIVE: counters hold their value. Invalid samples do not break the dwell streak.
- Shift timing: the shift occurs on the same edge that registers the DWELL-th qualifying sample. gear and M update together.
- M is a single-cycle pulse and returns to 00 on the next cycle.
- HOLD:
  - hold_cnt counts HOLD_CYC cycles, then exits to DRIVE (gear>0) or NEUTRAL (gear=0).
  - up_cnt and dn_cnt are held at 0 throughout.
  - rpm is ignored. No two shifts are ever closer than HOLD_CYC+DWELL cycles (except kickdown).
- Counters saturate at DWELL and never wrap. The comparison is unsigned over the full RPM_W width.
- Reset asserted mid-HOLD or mid-dwell: all state returns to reset values on that edge.

Optional Feature:
GEARBOX_KICKDOWN_EN
- Defined:
  - In DRIVE or HOLD with gear>1, a single valid sample with rpm<=KICK_TH forces gear-1 and M=10 on that edge.
  - Bypasses DWELL and any remaining hold time.
  - Re-enters HOLD with hold_cnt=0.
  - At gear==1 the normal dwell rule applies.
- Undefined: KICK_TH is unused, and low rpm follows only the normal DWELL/HOLD path.

Test Plan (defaults):
1. reset high 2 cycles, then A=1, rpm=0 -> gear=0, M=00, AC=0 during reset; AC=1 two cycles after reset release; state NEUTRAL.
2. NEUTRAL, rpm=210 valid for 4 cycles -> on 4th sample edge gear=1, M=01 for exactly 1 cycle. Keep rpm=210 -> next upshift to gear=2 exactly 8+4 cycles later.
3. DRIVE gear=3, rpm pattern 210,210,150,210,210,210,210 -> the 150 sample clears up_cnt; gear=4 only after the 4th consecutive 210.
4. gear=5, rpm=250 sustained 20 cycles -> gear stays 5, M stays 00. Then rpm=50 for 4 samples -> gear=4, M=10.
5. gear=1, rpm=60 for 4 samples -> gear=0, M=10, NEUTRAL after HOLD. Then drop A=0 mid-HOLD -> next cycle AC=0, gear=0, state OFF.
6. With GEARBOX_KICKDOWN_EN: gear=4 in HOLD, one sample rpm=20 -> gear=3, M=10 next edge. Without the macro, the same stimulus gives no change until hold expires and 4 qualifying samples arrive.
